// File: rtl/instruction_fetch.sv
// Fetch stage: issues word reads to a 1-cycle-latency instruction memory and delivers
// {inst, pc, valid} to decode through a 1-entry skid buffer. Optional macro: IF_BUBBLE_COUNTER_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          IM_ADDR_W    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [IM_ADDR_W-1:0] im_addr,
  output logic                 im_re,
  input  logic [31:0]          im_rdata,
  input  logic                 stall_id,
  input  logic                 redirect,
  input  logic [31:0]          redirect_pc,
  output logic                 if_valid,
  output logic [31:0]          if_inst,
  output logic [31:0]          if_pc,
`ifdef IF_BUBBLE_COUNTER_EN
  output logic [31:0]          bubble_count,
`endif
  output logic                 exception_inst_misaligned
);

  // state | meaning
  // RUN   | fetching sequentially from pc_fetch
  // HALT  | misaligned redirect delivered; no fetches until the next redirect
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        sk_valid_q, sk_valid_d;
  logic [31:0] sk_inst_q, sk_inst_d;
  logic [31:0] sk_pc_q, sk_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_exc_q, out_exc_d;
  logic        issue;

  assign issue   = (state_q == RUN) && !stall_id && !redirect;
  assign im_re   = issue && !reset;
  assign im_addr = pc_q[IM_ADDR_W+1:2];

  assign if_valid                  = out_valid_q;
  assign if_inst                   = out_inst_q;
  assign if_pc                     = out_pc_q;
  assign exception_inst_misaligned = out_exc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    f_valid_d   = f_valid_q;
    f_pc_d      = f_pc_q;
    sk_valid_d  = sk_valid_q;
    sk_inst_d   = sk_inst_q;
    sk_pc_d     = sk_pc_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_exc_d   = out_exc_q;

    if (redirect) begin
      pc_d       = redirect_pc;
      state_d    = RUN;
      f_valid_d  = 1'b0;
      sk_valid_d = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        // Deliver a single poisoned entry carrying the bad target, then park.
        out_valid_d = 1'b1;
        out_inst_d  = NOP;
        out_pc_d    = redirect_pc;
        out_exc_d   = 1'b1;
        state_d     = HALT;
      end else begin
        out_valid_d = 1'b0;
        out_exc_d   = 1'b0;
      end
    end else begin
      f_valid_d = issue;
      if (issue) begin
        f_pc_d = pc_q;
        pc_d   = pc_q + 32'd4;
      end

      if (!stall_id) begin
        out_exc_d = 1'b0;
        if (sk_valid_q) begin
          out_valid_d = 1'b1;
          out_inst_d  = sk_inst_q;
          out_pc_d    = sk_pc_q;
          sk_valid_d  = 1'b0;
        end else if (f_valid_q) begin
          out_valid_d = 1'b1;
          out_inst_d  = im_rdata;
          out_pc_d    = f_pc_q;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (f_valid_q) begin
        // Memory data cannot be re-read later, so park it while decode is stalled.
        sk_valid_d = 1'b1;
        sk_inst_d  = im_rdata;
        sk_pc_d    = f_pc_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_VECTOR;
      f_valid_q   <= 1'b0;
      f_pc_q      <= 32'h0;
      sk_valid_q  <= 1'b0;
      sk_inst_q   <= 32'h0;
      sk_pc_q     <= 32'h0;
      out_valid_q <= 1'b0;
      out_inst_q  <= NOP;
      out_pc_q    <= 32'h0;
      out_exc_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      f_valid_q   <= f_valid_d;
      f_pc_q      <= f_pc_d;
      sk_valid_q  <= sk_valid_d;
      sk_inst_q   <= sk_inst_d;
      sk_pc_q     <= sk_pc_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_exc_q   <= out_exc_d;
    end
  end

`ifdef IF_BUBBLE_COUNTER_EN
  logic [31:0] bubble_q, bubble_d;

  always_comb begin
    bubble_d = bubble_q;
    if (!stall_id && !out_valid_q && (bubble_q != 32'hFFFF_FFFF))
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) bubble_q <= 32'h0;
    else       bubble_q <= bubble_d;
  end

  assign bubble_count = bubble_q;
`endif

endmodule
